// File: rtl/inst_ctrl_queue_if.sv
// inst_ctrl_queue_if: enqueue/dequeue handshake and status bundle for the instruction control queue.
interface inst_ctrl_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN = 64,
  parameter int CTRL_W = 20
);
  logic flush;
  logic enq_valid;
  logic enq_ready;
  logic [XLEN-1:0] enq_addr;
  logic [31:0] enq_bits;
  logic [CTRL_W-1:0] enq_ctrl;
  logic enq_exc;
  logic deq_valid;
  logic deq_ready;
  logic [XLEN-1:0] deq_addr;
  logic [31:0] deq_bits;
  logic [CTRL_W-1:0] deq_ctrl;
  logic deq_exc;
  logic [$clog2(DEPTH):0] count;
  logic exc_locked;
  modport master (
    output flush, enq_valid, enq_addr, enq_bits, enq_ctrl, enq_exc, deq_ready,
    input enq_ready, deq_valid, deq_addr, deq_bits, deq_ctrl, deq_exc, count, exc_locked
  );
  modport slave (
    input flush, enq_valid, enq_addr, enq_bits, enq_ctrl, enq_exc, deq_ready,
    output enq_ready, deq_valid, deq_addr, deq_bits, deq_ctrl, deq_exc, count, exc_locked
  );
endinterface

// File: rtl/inst_ctrl_queue.sv
// inst_ctrl_queue: circular decoded-instruction queue that stops accepting after an exception
// entry until flushed; flush beats every handshake in the same cycle.
module inst_ctrl_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = 64,
  parameter int CTRL_W = 20
) (
  input logic clk,
  input logic rst,
  inst_ctrl_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [31:0] bits_mem [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic exc_mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic locked;
  logic enq, deq;
  // enq_ready is held low during reset even though the state already reads empty
  assign q.enq_ready = !rst && (cnt < CW'(DEPTH)) && !locked;
  assign q.deq_valid = cnt != '0;
  assign enq = q.enq_valid && q.enq_ready && !q.flush;
  assign deq = q.deq_valid && q.deq_ready && !q.flush;
  assign q.deq_addr = addr_mem[rp];
  assign q.deq_bits = bits_mem[rp];
  assign q.deq_ctrl = ctrl_mem[rp];
  assign q.deq_exc = exc_mem[rp];
  assign q.count = cnt;
  assign q.exc_locked = locked;
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wp] <= q.enq_addr;
      bits_mem[wp] <= q.enq_bits;
      ctrl_mem[wp] <= q.enq_ctrl;
      exc_mem[wp] <= q.enq_exc;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      locked <= 1'b0;
    end else if (q.flush) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      locked <= 1'b0;
    end else begin
      rp <= deq ? rp + AW'(1) : rp;
      wp <= enq ? wp + AW'(1) : wp;
      cnt <= cnt + CW'(enq) - CW'(deq);
      locked <= locked || (enq && q.enq_exc);
    end
  end
endmodule

// File: doc/inst_ctrl_queue.md
INST_CTRL_QUEUE -- requirements
Module: inst_ctrl_queue

Interface
REQ-001 Parameter DEPTH, default 4; entry count, power of two, >= 2.
REQ-002 Parameter XLEN, default 64; instruction address width.
REQ-003 Parameter CTRL_W, default 20; width of the packed decoded-control word (itype, rwb_en, is_* flags, funct3, funct7).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  discard all entries and clear the exception lock.
REQ-007 enq_valid  input  1  producer offers an entry.
REQ-008 enq_ready  output  1  queue accepts an entry this cycle.
REQ-009 enq_addr  input  XLEN  instruction address.
REQ-010 enq_bits  input  32  raw instruction word.
REQ-011 enq_ctrl  input  CTRL_W  decoded control word.
REQ-012 enq_exc  input  1  entry carries a pending exception.
REQ-013 deq_valid  output  1  head entry available.
REQ-014 deq_ready  input  1  consumer takes the head entry.
REQ-015 deq_addr / deq_bits / deq_ctrl / deq_exc  output  XLEN / 32 / CTRL_W / 1  head entry fields.
REQ-016 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-017 exc_locked  output  1  an exception entry has been enqueued since the last flush or reset.

Function
REQ-018 Storage SHALL be a circular buffer: read pointer, write pointer and count, with both pointers wrapping from DEPTH-1 to 0.
REQ-019 An enqueue SHALL occur when enq_valid && enq_ready && !flush; a dequeue SHALL occur when deq_valid && deq_ready && !flush.
REQ-020 enq_ready SHALL be (count < DEPTH) && !exc_locked, and SHALL NOT depend combinationally on deq_ready; a full queue refuses an enqueue even when a dequeue happens in the same cycle.
REQ-021 deq_valid SHALL be (count != 0); deq_* fields SHALL come from the entry at the read pointer; their value when deq_valid=0 is don't-care.
REQ-022 There SHALL be no bypass: an entry enqueued in cycle N is first visible on deq_* in cycle N+1.
REQ-023 A simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-024 Entries SHALL leave in enqueue order, with every field bit-exact.
REQ-025 Enqueueing an entry with enq_exc=1 SHALL set exc_locked from the next cycle; the locked state SHALL hold while the queue drains, including the exception entry itself.
REQ-026 flush SHALL take priority over every other event: in the next cycle count=0, both pointers are 0 and exc_locked=0; an enq or deq handshake in the flush cycle has no effect.
REQ-027 Storage contents SHALL NOT need clearing on flush or reset; only pointers, count and exc_locked are state.
REQ-028 count SHALL never exceed DEPTH and never underflow.

Reset
REQ-029 While rst=1, pointers SHALL be 0, count=0, exc_locked=0, deq_valid=0 and enq_ready=0.
REQ-030 In the first cycle after rst deasserts, enq_ready SHALL be 1; reset during activity SHALL discard all entries immediately and asynchronously.

Verification
REQ-031 Fill: DEPTH=4, enqueue addr 0x100,0x104,0x108,0x10C with deq_ready=0 -> count=4, enq_ready=0, deq_addr=0x100.
REQ-032 Full plus simultaneous: with the queue full, enq_valid=1 and deq_ready=1 -> 0x100 leaves, the new entry is refused, count=3; the next cycle enq_ready=1.
REQ-033 Wrap: 10 back-to-back enqueue/dequeue pairs with addr 0x0..0x24 step 4 -> deq_addr sequence identical to the input, count stays at 1 after the first, no loss across the pointer wrap.
REQ-034 Exception lock: enqueue 0x200 (exc=0), then 0x204 (exc=1), then offer 0x208 -> enq_ready=0 from the cycle after 0x204; deq yields 0x200 then 0x204 with deq_exc=1; 0x208 is never accepted; then flush -> exc_locked=0, enq_ready=1.
REQ-035 Flush collision: queue holds 3 entries; flush=1 with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, and the offered entry is absent.
REQ-036 Async reset: assert rst mid-cycle with count=2 -> count=0, deq_valid=0 before the next clock edge.
